// File: rtl/multalu_pkg.sv
// Shared constants for the multiply/ALU MAC: op encodings and pipeline depth.
// Small helpers decode the op field so the datapath reads in its own terms.
package multalu_pkg;

    localparam logic [1:0] OP_CADD = 2'b00;
    localparam logic [1:0] OP_CSUB = 2'b01;
    localparam logic [1:0] OP_AADD = 2'b10;
    localparam logic [1:0] OP_ASUB = 2'b11;

    localparam int MAC_LATENCY = 3;

    // op[1] selects the accumulator instead of c as the ALU base operand
    function automatic logic op_uses_acc(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_sub(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/multalu_mac_if.sv
// Sample/result bundle of the MAC. The master drives the operands and the
// pipeline enable; the slave (the MAC) returns the registered result.
interface multalu_mac_if #(
    parameter int A_W   = 18,
    parameter int B_W   = 18,
    parameter int OUT_W = 54
);

    logic             ce;
    logic             in_valid;
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic [OUT_W-1:0] c;
    logic             asign;
    logic             bsign;
    logic [1:0]       op;
    logic             out_valid;
    logic [OUT_W-1:0] dout;
    logic             ovf;

    modport master (
        output ce,
        output in_valid,
        output a,
        output b,
        output c,
        output asign,
        output bsign,
        output op,
        input  out_valid,
        input  dout,
        input  ovf
    );

    modport slave (
        input  ce,
        input  in_valid,
        input  a,
        input  b,
        input  c,
        input  asign,
        input  bsign,
        input  op,
        output out_valid,
        output dout,
        output ovf
    );

endinterface

// File: rtl/multalu_sat.sv
// Range check and optional clamp of the two-guard-bit ALU sum down to OUT_W.
// Purely combinational; the caller registers both outputs.
module multalu_sat
    import multalu_pkg::*;
#(
    parameter int OUT_W    = 54,
    parameter int SATURATE = 0
) (
    input  logic signed [OUT_W+1:0] sum_i,
    output logic        [OUT_W-1:0] dout_o,
    output logic                    ovf_o
);

    logic [OUT_W-1:0] max_val;
    logic [OUT_W-1:0] min_val;
    logic             in_range;

    always_comb begin
        max_val  = {1'b0, {(OUT_W-1){1'b1}}};
        min_val  = {1'b1, {(OUT_W-1){1'b0}}};
        // the sum fits the signed OUT_W range only if the two guard bits echo its sign
        in_range = (sum_i[OUT_W+1] == sum_i[OUT_W]) && (sum_i[OUT_W] == sum_i[OUT_W-1]);
        ovf_o    = !in_range;
        dout_o   = sum_i[OUT_W-1:0];
        if ((SATURATE != 0) && !in_range) begin
            dout_o = sum_i[OUT_W+1] ? min_val : max_val;
        end
    end

endmodule

// File: rtl/multalu_mac.sv
// Three-stage multiply-add/accumulate: S1 operand registers, S2 product
// register, S3 ALU result register that doubles as the accumulator.
module multalu_mac
    import multalu_pkg::*;
#(
    parameter int A_W      = 18,
    parameter int B_W      = 18,
    parameter int OUT_W    = 54,
    parameter int SATURATE = 0
) (
    input logic          clk,
    input logic          reset,
    multalu_mac_if.slave bus
);

    localparam int P_W = A_W + B_W + 2;
    localparam int S_W = OUT_W + 2;

    if (OUT_W < A_W + B_W) begin : g_width_check
        $error("multalu_mac: OUT_W must be at least A_W+B_W");
    end

    // valid_q[k] qualifies the data held in stage k+1
    logic valid_q [MAC_LATENCY];

    logic [A_W-1:0]   a_q;
    logic [B_W-1:0]   b_q;
    logic             asign_q;
    logic             bsign_q;
    logic [OUT_W-1:0] c1_q;
    logic [1:0]       op1_q;

    logic signed [A_W:0]   a_ext;
    logic signed [B_W:0]   b_ext;
    logic signed [P_W-1:0] prod_d;
    logic signed [P_W-1:0] prod_q;
    logic [OUT_W-1:0]      c2_q;
    logic [1:0]            op2_q;

    logic signed [S_W-1:0] p_ext;
    logic signed [S_W-1:0] base_ext;
    logic signed [S_W-1:0] sum_d;
    logic [OUT_W-1:0]      dout_d;
    logic [OUT_W-1:0]      dout_q;
    logic                  ovf_d;
    logic                  ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q[0] <= 1'b0;
        end else if (bus.ce) begin
            valid_q[0] <= bus.in_valid;
        end
    end

    for (genvar gi = 1; gi < MAC_LATENCY; gi++) begin : g_valid
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q[gi] <= 1'b0;
            end else if (bus.ce) begin
                valid_q[gi] <= valid_q[gi-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            asign_q <= 1'b0;
            bsign_q <= 1'b0;
            c1_q    <= '0;
            op1_q   <= '0;
        end else if (bus.ce) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            asign_q <= bus.asign;
            bsign_q <= bus.bsign;
            c1_q    <= bus.c;
            op1_q   <= bus.op;
        end
    end

    // one extra bit per operand lets a single signed multiply serve all sign mixes
    assign a_ext  = signed'({asign_q & a_q[A_W-1], a_q});
    assign b_ext  = signed'({bsign_q & b_q[B_W-1], b_q});
    assign prod_d = P_W'(a_ext) * P_W'(b_ext);

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            c2_q   <= '0;
            op2_q  <= '0;
        end else if (bus.ce) begin
            prod_q <= prod_d;
            c2_q   <= c1_q;
            op2_q  <= op1_q;
        end
    end

    // the accumulator is read straight from the result register, so consecutive
    // accumulate samples chain without any forwarding
    always_comb begin
        p_ext    = S_W'(prod_q);
        base_ext = op_uses_acc(op2_q) ? S_W'(signed'(dout_q)) : S_W'(signed'(c2_q));
        sum_d    = op_is_sub(op2_q) ? (base_ext - p_ext) : (base_ext + p_ext);
    end

    multalu_sat #(
        .OUT_W    (OUT_W),
        .SATURATE (SATURATE)
    ) u_sat (
        .sum_i  (sum_d),
        .dout_o (dout_d),
        .ovf_o  (ovf_d)
    );

    // bubbles leave the result/accumulator untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
            ovf_q  <= 1'b0;
        end else if (bus.ce && valid_q[MAC_LATENCY-2]) begin
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.out_valid = valid_q[MAC_LATENCY-1];
    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: doc/multalu_mac.md
MULTALU_MAC -- requirements
Module: multalu_mac

Interface
REQ-001 Parameter A_W, default 18: width of multiplier operand a.
REQ-002 Parameter B_W, default 18: width of multiplier operand b.
REQ-003 Parameter OUT_W, default 54: width of c, dout and accumulator; OUT_W >= A_W+B_W is enforced by an elaboration-time check.
REQ-004 Parameter SATURATE, default 0: 0 = wrap modulo 2^OUT_W; 1 = clamp to the signed OUT_W range.
REQ-005 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: reset is synchronous and active-high.
REQ-007 Port ce, input, 1: pipeline advance enable; 0 freezes every register.
REQ-008 Port in_valid, input, 1: a, b, c, asign, bsign and op carry a sample this cycle.
REQ-009 Port a, input, A_W: multiplicand.
REQ-010 Port b, input, B_W: multiplier.
REQ-011 Port c, input, OUT_W: addend.
REQ-012 Port asign / bsign, input, 1 each: 1 = corresponding operand is two's complement; 0 = unsigned.
REQ-013 Port op, input, 2: 00 = C+P; 01 = C-P; 10 = ACC+P; 11 = ACC-P (P = a*b).
REQ-014 Port out_valid, output, 1: dout/ovf hold a new result this cycle.
REQ-015 Port dout, output, OUT_W: result register, which is also the accumulator (ACC).
REQ-016 Port ovf, output, 1: the result in dout exceeded the signed OUT_W range.

Function
REQ-017 Pipeline is three stages: S1 input registers; S2 product register; S3 ALU/result register. A sample accepted at edge N with ce held at 1 appears with out_valid=1 after edge N+2.
REQ-018 Stage advance occurs only on edges where ce=1; with ce=0, all data and valid registers hold, and out_valid keeps its value.
REQ-019 A valid bit travels with each stage; in_valid=0 inserts a bubble, and bubbles never modify dout, ovf or ACC.
REQ-020 Operand extension: each operand is extended by one bit, using its MSB when its sign flag is 1 and 0 otherwise. The product is computed at A_W+B_W+2 bits, then sign-extended to OUT_W+2 bits.
REQ-021 ALU operations are computed at OUT_W+2 bits. c is treated as signed OUT_W. ACC is the current dout.
REQ-022 ACC feedback comes directly from the S3 register, so back-to-back op=10/11 samples each see the immediately preceding result (no hazard, no stall).
REQ-023 ovf=1 when the OUT_W+2-bit sum lies outside [-2^(OUT_W-1), 2^(OUT_W-1)-1]; ovf is registered with dout and is not sticky.
REQ-024 With SATURATE=0, dout = sum[OUT_W-1:0]. With SATURATE=1, dout is clamped to 2^(OUT_W-1)-1 or -2^(OUT_W-1) according to the sum's sign.
REQ-025 op=10/11 as the first sample after reset uses ACC=0.
REQ-026 reset and ce=1 in the same cycle: reset wins.

Reset
REQ-027 reset=1 at a clock edge clears all valid bits, dout, ovf and the S1/S2 data registers to 0, regardless of ce.
REQ-028 Samples in flight at reset are discarded; no out_valid pulse from them appears after reset is released.
REQ-029 The first in_valid sample is accepted on the first edge where reset=0.

Structure
REQ-030 Package multalu_pkg holds the op encoding localparams (OP_CADD, OP_CSUB, OP_AADD, OP_ASUB) and the stage-count constant MAC_LATENCY=3.
REQ-031 Saturation/overflow detection is sub-module multalu_sat (parameter OUT_W; input OUT_W+2-bit sum; outputs dout value and ovf); it is combinational and instantiated once in S3.

Verification
REQ-032 Signed MAC: a=-3, b=5, c=100, asign=bsign=1, op=00 -> exactly 2 edges later dout=85, out_valid=1, ovf=0.
REQ-033 Unsigned: a=18'h3FFFF, b=2, asign=bsign=0, c=0, op=00 -> dout=524286.
REQ-034 Back-to-back accumulate on consecutive cycles: (2,3,c=0,op=00), (4,5,op=10), (1,1,op=11) -> dout 6, 26, 25 on consecutive cycles.
REQ-035 Same stream as REQ-034 with ce=0 for 2 cycles after the second sample -> identical values; out_valid is held (not re-pulsed as new) during the stall; total latency is extended by 2.
REQ-036 OUT_W=36: op=00 with c=2^35-1, a=b=0, then op=10 with a=b=1 -> SATURATE=1: dout=2^35-1, ovf=1; SATURATE=0: dout=-2^35, ovf=1.
REQ-037 Three valid samples in flight, reset=1 for one cycle -> next edge out_valid=0, dout=0, ovf=0; no stale result afterwards; op=10 with a=b=2 then gives dout=4.
